// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// port and the load/store port of the riscv32 core.
//
// A three-state FSM (IDLE -> BUSY -> RESP) serializes one access at a time
// onto the mem_* channel. The FSM tolerates variable memory latency and aborts
// an access that is still outstanding after TO_CYC cycles. An aborted access
// completes with err=1 and rdata=0.
//
// Optional feature: define MEM_ARB_RR_EN to use round-robin arbitration
// between the two requesters. When it is undefined, data has fixed priority
// over fetch and the last-grant register is not built.
module mem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TO_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,

    // instruction-fetch requester
    input  logic              i_req,
    input  logic [AW-1:0]     i_addr,
    output logic              i_ack,
    output logic [DW-1:0]     i_rdata,

    // load/store requester
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    input  logic [DW/8-1:0]   d_be,
    output logic              d_ack,
    output logic [DW-1:0]     d_rdata,

    output logic              err,

    // memory channel
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_be,
    input  logic              mem_ack,
    input  logic [DW-1:0]     mem_rdata
);

    // The counter only has to reach TO_CYC-1 (TO_CYC >= 2 keeps CW >= 1).
    localparam int            CW      = $clog2(TO_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(TO_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          owner_d;   // 1: the access in flight belongs to the data port
    logic          grant_d;   // arbitration result, meaningful only in IDLE

`ifdef MEM_ARB_RR_EN
    logic last_d;             // 1: data was granted most recently

    // On a tie, the requester that was not granted last wins.
    always_comb begin
        grant_d = d_req && (!i_req || !last_d);
    end

    // Remember the winner of each IDLE->BUSY transition. After reset, fetch
    // counts as the last grant, so data wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d <= 1'b0;
        end else if (state == IDLE && (i_req || d_req)) begin
            last_d <= grant_d;
        end
    end
`else
    // Fixed priority: data always beats fetch.
    always_comb begin
        grant_d = d_req;
    end
`endif

    // Main FSM. All outputs are registered. The FSM samples requester inputs
    // only in IDLE, so input changes during BUSY/RESP do not affect the
    // access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            owner_d   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner_d <= grant_d;
                        mem_req <= 1'b1;
                        cnt     <= '0;
                        state   <= BUSY;
                        if (grant_d) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_be    <= d_be;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            mem_be    <= '1;
                        end
                    end
                end

                BUSY: begin
                    // mem_ack takes precedence over expiry in the same cycle.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        err     <= 1'b0;
                        state   <= RESP;
                        if (owner_d) begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_ack   <= 1'b1;
                        end
                    end else if (cnt == CNT_MAX) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        state   <= RESP;
                        if (owner_d) begin
                            d_rdata <= '0;
                            d_ack   <= 1'b1;
                        end else begin
                            i_rdata <= '0;
                            i_ack   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                RESP: begin
                    // The ack pulse lasts exactly this one cycle.
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. Requesters and the memory are driven with random
// addresses, data and latencies. Each access is predicted at the transaction
// level: who wins (arbitration policy), which command must appear on mem_*,
// and when the ack must arrive and with what data and err value.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            i_req = 1'b0;
    logic [AW-1:0]   i_addr = '0;
    logic            i_ack;
    logic [DW-1:0]   i_rdata;
    logic            d_req = 1'b0;
    logic            d_we = 1'b0;
    logic [AW-1:0]   d_addr = '0;
    logic [DW-1:0]   d_wdata = '0;
    logic [DW/8-1:0] d_be = '0;
    logic            d_ack;
    logic [DW-1:0]   d_rdata;
    logic            err;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_ack = 1'b0;
    logic [DW-1:0]   mem_rdata = '0;

    mem_arbiter #(.AW(AW), .DW(DW), .TO_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: last data each requester was given, and who was
    // served last (only consulted by the round-robin policy).
    logic [DW-1:0] m_i_rd = '0;
    logic [DW-1:0] m_d_rd = '0;
    bit            m_last_d = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Winner for the pending request set under the configured policy.
    function automatic bit pick_d(input bit ip, input bit dp);
`ifdef MEM_ARB_RR_EN
        if (ip && dp) return !m_last_d;
`endif
        return dp;
    endfunction

    // Serve one access. The caller is in an IDLE cycle with the requests set.
    // lat = 0: the memory never acks (timeout); otherwise mem_ack comes on the
    // lat-th cycle of mem_req. renew: a winning data port re-requests at once.
    task automatic do_access(input int lat, input bit renew, input logic [DW-1:0] rd);
        bit wd, stable, seen;
        logic [AW-1:0]   ea;
        logic [DW-1:0]   ewd, erd;
        logic [DW/8-1:0] ebe;
        logic            ewe;
        int n, w, exp_n;
        wd = pick_d(i_req, d_req);
        if (wd) begin ea = d_addr; ewe = d_we; ewd = d_wdata; ebe = d_be; end
        else    begin ea = i_addr; ewe = 1'b0; ewd = '0;      ebe = '1;   end
        m_last_d = wd;
        step();
        mem_ack = 1'b0;
        w = 0;
        while (!mem_req && w < 4) begin step(); w++; end
        chk("mem_req_rise", 64'(mem_req), 64'(1));
        if (!mem_req) begin i_req = 1'b0; d_req = 1'b0; return; end
        n = 1; stable = 1'b1; seen = 1'b0;
        while (1) begin
            if (!mem_req || mem_addr !== ea || mem_we !== ewe ||
                mem_wdata !== ewd || mem_be !== ebe) stable = 1'b0;
            // The winner's inputs may change mid-access without effect.
            if (n == 1) begin
                if (wd) begin d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom); end
                else i_addr = $urandom;
            end
            mem_ack   = (lat != 0 && n == lat);
            mem_rdata = mem_ack ? rd : $urandom;
            step();
            n++;
            mem_ack = 1'b0;
            if (i_ack || d_ack) begin seen = 1'b1; break; end
            if (n > TO + 4) break;
        end
        exp_n = (lat == 0) ? TO + 1 : lat + 1;
        erd   = (lat == 0) ? '0 : rd;
        if (wd) m_d_rd = erd; else m_i_rd = erd;
        chk("busy_cmd_stable", 64'(stable), 64'(1));
        chk("ack_seen", 64'(seen), 64'(1));
        chk("ack_cycle", 64'(n), 64'(exp_n));
        chk("ack_owner", 64'({i_ack, d_ack}), wd ? 64'(2'b01) : 64'(2'b10));
        chk("err", 64'(err), 64'(lat == 0));
        chk("i_rdata", 64'(i_rdata), 64'(m_i_rd));
        chk("d_rdata", 64'(d_rdata), 64'(m_d_rd));
        chk("mem_req_in_resp", 64'(mem_req), 64'(0));
        // Drop or renew on the edge that ends the ack cycle.
        if (wd) begin
            if (renew) begin
                d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
            end else d_req = 1'b0;
        end else i_req = 1'b0;
        // mem_ack in RESP and IDLE must be ignored.
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        step();
        chk("ack_clear", 64'({i_ack, d_ack, err}), 64'(0));
        mem_ack = 1'($urandom); mem_rdata = $urandom;
    endtask

    task automatic new_fetch(input logic [AW-1:0] a);
        i_req = 1'b1; i_addr = a;
    endtask

    task automatic new_data(input bit we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [DW/8-1:0] be);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    endtask

    initial begin
        int lat, r, g;
        // Reset state
        #23;
        chk("rst_outs", 64'({mem_req, mem_we, i_ack, d_ack, err}), 64'(0));
        chk("rst_mem", 64'({mem_addr, mem_wdata}), 64'(0));
        chk("rst_be_rdata", 64'({mem_be, i_rdata, d_rdata}), 64'(0));
        @(negedge clk); rst = 1'b1;
        step();
        chk("idle_no_req", 64'({mem_req, i_ack, d_ack}), 64'(0));

        // Single fetch, 1-cycle memory
        new_fetch(32'h40);
        do_access(1, 1'b0, 32'h00500093);

        // Store, 3-cycle memory
        new_data(1'b1, 32'h100, 32'hDEADBEEF, 4'b0011);
        do_access(3, 1'b0, $urandom);

        // Both held for 4 transactions, data renewing
        new_fetch($urandom);
        new_data(1'b0, $urandom, $urandom, 4'hF);
        repeat (4) do_access(1 + int'($urandom_range(0, 2)), 1'b1, $urandom);
        g = 0;
        while ((i_req || d_req) && g < 4) begin do_access(2, 1'b0, $urandom); g++; end

        // Timeout, then mem_ack coincident with expiry
        new_data(1'b0, 32'h200, 32'h0, 4'hF);
        do_access(0, 1'b0, $urandom);
        new_fetch(32'h300);
        do_access(TO, 1'b0, $urandom);
        new_fetch(32'h304);
        do_access(0, 1'b0, $urandom);

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            if (!i_req && $urandom_range(0, 1) == 1) new_fetch($urandom);
            if (!d_req && ($urandom_range(0, 1) == 1 || !i_req))
                new_data(1'($urandom), $urandom, $urandom, 4'($urandom));
            r = int'($urandom_range(0, 15));
            lat = (r == 0) ? 0 : (r == 1) ? TO : 1 + (r % 4);
            do_access(lat, $urandom_range(0, 2) == 0, $urandom);
        end
        g = 0;
        while ((i_req || d_req) && g < 4) begin do_access(1, 1'b0, $urandom); g++; end

        // Reset pulled mid-BUSY
        mem_ack = 1'b0;
        new_data(1'b1, 32'h500, 32'h12345678, 4'hF);
        step(); step();
        chk("busy_before_rst", 64'(mem_req), 64'(1));
        #2 rst = 1'b0;
        #1;
        chk("rst_async_outs", 64'({mem_req, i_ack, d_ack, err}), 64'(0));
        chk("rst_async_rdata", 64'({i_rdata, d_rdata}), 64'(0));
        m_i_rd = '0; m_d_rd = '0; m_last_d = 1'b0;
        d_req = 1'b0;
        @(negedge clk); rst = 1'b1;
        r = 0;
        for (int k = 0; k < 4; k++) begin
            mem_ack = 1'($urandom);
            step();
            r = r | int'({i_ack, d_ack, mem_req});
        end
        mem_ack = 1'b0;
        chk("no_stale_ack", 64'(r), 64'(0));
        new_fetch(32'h600);
        new_data(1'b0, 32'h700, 32'h0, 4'hF);
        do_access(2, 1'b0, $urandom);
        do_access(1, 1'b0, $urandom);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port unified instruction/data memory of the riscv32 core between the instruction-fetch port and the load/store port. Each requester gets its own req/ack handshake. A three-state FSM serializes accesses onto one memory request channel, tolerates variable memory latency and aborts hung accesses with a timeout. It sits between the core datapath and the memory model, and is the prerequisite for the multi-cycle core variant.

## Interface
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8 wide)
- TO_CYC, 64, max cycles a memory access may stay outstanding before abort; must be ≥ 2
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  AW  fetch address, stable while i_req
- i_ack  out  1  one-cycle completion pulse for fetch
- i_rdata  out  DW  fetch data, valid when i_ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_be  in  DW/8  store byte enables
- d_ack  out  1  one-cycle completion pulse for data
- d_rdata  out  DW  load data, valid when d_ack
- err  out  1  high with i_ack/d_ack if the access timed out
- mem_req  out  1  memory request, held until mem_ack or abort
- mem_we, mem_addr, mem_wdata, mem_be  out  1/AW/DW/DW/8  memory command, registered, stable while mem_req
- mem_ack  in  1  memory completion, one cycle
- mem_rdata  in  DW  read data, valid with mem_ack

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any req is high, pick a winner.
  - Register its command onto mem_* (fetch: mem_we=0, mem_be=all ones, mem_wdata=0).
  - Set mem_req=1, clear the timeout counter, go to BUSY.
  - If no req is high, stay in IDLE.
- Default arbitration is fixed priority: data beats fetch.
- BUSY:
  - Counter increments each cycle.
  - On mem_ack: latch mem_rdata into the winner's rdata, set mem_req=0, err=0, go to RESP.
  - If the counter reaches TO_CYC-1 without mem_ack: set mem_req=0, rdata=0, err=1, go to RESP.
  - If mem_ack and expiry occur in the same cycle, mem_ack wins (err=0).
- RESP:
  - The winner's ack is high for exactly one cycle; the other ack stays 0.
  - Next state is IDLE.
- Requesters drop or renew req on the edge that ends their ack cycle. A req seen in IDLE is always a new transaction.
- The loser's req is held pending without side effects. It is served on the next IDLE pass.
- Inputs are sampled only in IDLE. Changes to requester inputs during BUSY/RESP have no effect on the in-flight access.
- rdata outputs hold their last value between acks.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, i_ack=d_ack=0, err=0, i_rdata=d_rdata=0, counter=0. The round-robin pointer (see Configuration) resets to fetch-last.
- Reset assertion mid-access clears all outputs immediately and asynchronously. The in-flight access is dropped with no ack; memory must tolerate mem_req falling.
- Latency:
  - req high in IDLE at cycle 0 → mem_req high from cycle 1.
  - mem_ack at cycle k ≥ 1 → ack at cycle k+1.
  - Minimum req-to-ack is 2 cycles; minimum back-to-back throughput is one access per 3 cycles.
- Timeout ack lands at cycle TO_CYC+1 after the request cycle.
- mem_ack arriving in IDLE or RESP is ignored.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A one-bit last-grant register is updated on every IDLE→BUSY transition.
  - When both requesters are high in IDLE, the one not granted last wins.
  - After reset, data wins the first tie.
- MEM_ARB_RR_EN undefined: fixed priority, data over fetch. The last-grant register is not built.

## Test plan
- Single fetch, i_addr=0x40, memory acks 1 cycle after mem_req with 0x00500093 → mem_req cycles 1–1, i_ack at cycle 2, i_rdata=0x00500093, err=0, d_ack never high.
- Store d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b0011, 3-cycle memory latency → mem_we=1, mem_be=0011, mem_wdata stable for 3 cycles, d_ack at cycle 4.
- i_req and d_req both held for 4 transactions:
  - Without the macro: order D,D,D,D while d_req stays high, fetch starved.
  - With MEM_ARB_RR_EN: order D,I,D,I.
- Memory never acks, TO_CYC=64 → mem_req drops after 64 BUSY cycles, ack+err high at cycle 65, rdata=0, FSM back to IDLE.
- mem_ack coincident with the timeout cycle → ack with err=0 and memory data.
- rst pulled low during BUSY → mem_req and all acks 0 immediately. After release, a fresh d_req completes normally with no stale ack.
